// File: rtl/vmem_pkg.sv
// ---------------------------------------------------------------------------
// vmem_pkg
//   Shared types and default sizing for the vector memory access engine.
//   vmem_state_e : engine state (IDLE / ACCESS / DONE)
//   VMEM_VL, VMEM_SEW, VMEM_ADDR_W : default vector length, element width
//                                    and byte-address width
//   ELEM_BYTES   : bytes per element at the default SEW
//   IDX_W        : element index width at the default VL
// ---------------------------------------------------------------------------
package vmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } vmem_state_e;

   localparam int VMEM_VL     = 8;
   localparam int VMEM_SEW    = 32;
   localparam int VMEM_ADDR_W = 32;
   localparam int ELEM_BYTES  = VMEM_SEW / 8;
   localparam int IDX_W       = $clog2(VMEM_VL);

   // Bytes per element for an arbitrary element width.
   function automatic int elem_bytes(input int sew);
      return sew / 8;
   endfunction

endpackage

// File: rtl/vmem_addr_gen.sv
// ---------------------------------------------------------------------------
// vmem_addr_gen
//   Holds the vector base address and produces the byte address of the
//   current element: base + idx * ELEM_BYTES, wrapping modulo 2^ADDR_W.
//   clk   in  clock, rising edge
//   rst   in  synchronous reset, active-low (clears the base register)
//   load  in  capture base this cycle
//   base  in  base byte address
//   idx   in  element index
//   addr  out element byte address
// ---------------------------------------------------------------------------
module vmem_addr_gen #(
   parameter int ADDR_W     = 32,
   parameter int IDX_W      = 3,
   parameter int ELEM_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic [IDX_W-1:0]  idx,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] base_reg;
   logic [ADDR_W-1:0] offset;

   always_ff @(posedge clk) begin
      if (!rst) begin
         base_reg <= '0;
      end else if (load) begin
         base_reg <= base;
      end
   end

   // Sum is truncated to ADDR_W, so a run crossing the top of the address
   // space simply wraps to zero.
   assign offset = ADDR_W'(idx) * ADDR_W'(ELEM_BYTES);
   assign addr   = base_reg + offset;

endmodule

// File: rtl/vec_mem_access.sv
// ---------------------------------------------------------------------------
// vec_mem_access
//   Unit-stride vector load/store engine. One accepted request is executed as
//   VL sequential SEW-wide accesses on a single-port memory with a ready
//   handshake; the pipeline is stalled until the last element completes and
//   the assembled load vector is presented with a one-cycle done pulse.
//
//   Optional feature macro: VMEM_MASK_EN (adds req_mask; masked-off elements
//   are skipped without a memory access and read back as zero).
//
//   clk, rst            clock (rising edge), synchronous active-low reset
//   req_valid/store     request strobe, 1 = store / 0 = load
//   req_addr/be/wdata   base byte address, store byte enables, store vector
//   req_mask            element mask (VMEM_MASK_EN only)
//   busy, stall, done   engine active, upstream freeze, completion pulse
//   rdata_v             assembled load vector (held until next accept)
//   mem_*               single-port memory interface
// ---------------------------------------------------------------------------
module vec_mem_access
   import vmem_pkg::*;
#(
   parameter int VL     = VMEM_VL,
   parameter int SEW    = VMEM_SEW,
   parameter int ADDR_W = VMEM_ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_store,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [SEW/8-1:0]    req_be,
   input  logic [VL*SEW-1:0]   req_wdata,
`ifdef VMEM_MASK_EN
   input  logic [VL-1:0]       req_mask,
`endif
   output logic                busy,
   output logic                stall,
   output logic                done,
   output logic [VL*SEW-1:0]   rdata_v,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [SEW/8-1:0]    mem_be,
   output logic [SEW-1:0]      mem_wdata,
   input  logic [SEW-1:0]      mem_rdata,
   input  logic                mem_ready
);

   localparam int EB = elem_bytes(SEW);
   localparam int IW = (VL > 1) ? $clog2(VL) : 1;

   vmem_state_e        state_reg;
   logic [IW-1:0]      idx_reg;
   logic               store_reg;
   logic [EB-1:0]      be_reg;
   logic [VL*SEW-1:0]  wdata_reg;
   logic [VL*SEW-1:0]  rdata_reg;
   logic [ADDR_W-1:0]  elem_addr;
   logic               accept;
   logic               elem_active;
   logic               elem_done;
   logic               last_elem;

`ifdef VMEM_MASK_EN
   logic [VL-1:0]      mask_reg;
   assign elem_active = mask_reg[idx_reg];
`else
   assign elem_active = 1'b1;
`endif

   assign accept    = (state_reg == IDLE) && req_valid;
   assign last_elem = (idx_reg == IW'(VL - 1));
   // A skipped element retires in one cycle regardless of mem_ready.
   assign elem_done = (state_reg == ACCESS) && (!elem_active || mem_ready);

   vmem_addr_gen #(
      .ADDR_W     (ADDR_W),
      .IDX_W      (IW),
      .ELEM_BYTES (EB)
   ) u_addr_gen (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .base (req_addr),
      .idx  (idx_reg),
      .addr (elem_addr)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         store_reg <= 1'b0;
         be_reg    <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
`ifdef VMEM_MASK_EN
         mask_reg  <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  store_reg <= req_store;
                  be_reg    <= req_be;
                  wdata_reg <= req_wdata;
`ifdef VMEM_MASK_EN
                  mask_reg  <= req_mask;
`endif
                  rdata_reg <= '0;
                  idx_reg   <= '0;
                  state_reg <= ACCESS;
               end
            end
            ACCESS: begin
               if (elem_done) begin
                  if (elem_active && !store_reg) begin
                     rdata_reg[idx_reg*SEW +: SEW] <= mem_rdata;
                  end
                  if (last_elem) begin
                     state_reg <= DONE;
                  end else begin
                     idx_reg <= idx_reg + IW'(1);
                  end
               end
            end
            DONE: begin
               // Any request presented here is dropped; the MEM stage
               // re-presents it once stall has released.
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Memory-side outputs are forced to zero whenever no access is issued so
   // the bus is quiet in IDLE/DONE and immediately after reset.
   assign mem_en    = (state_reg == ACCESS) && elem_active;
   assign mem_we    = mem_en && store_reg;
   assign mem_addr  = mem_en ? elem_addr : '0;
   assign mem_be    = mem_en ? (store_reg ? be_reg : '1) : '0;
   assign mem_wdata = mem_we ? wdata_reg[idx_reg*SEW +: SEW] : '0;

   assign busy    = (state_reg != IDLE);
   assign done    = (state_reg == DONE);
   assign stall   = accept || (state_reg == ACCESS);
   assign rdata_v = rdata_reg;

endmodule

// File: tb/tb_vec_mem_access.sv
// ---------------------------------------------------------------------------
// tb_vec_mem_access
//   Directed bench for vec_mem_access. A memory responder returns the
//   accessed address as load data and can insert wait states; an expected
//   access queue and expected load vector are derived from each request.
// ---------------------------------------------------------------------------
module tb_vec_mem_access;

   localparam int VL  = 8;
   localparam int SEW = 32;
   localparam int AW  = 32;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } txn_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_store = 1'b0;
   logic [AW-1:0]   req_addr = '0;
   logic [3:0]      req_be = '0;
   logic [255:0]    req_wdata = '0;
   logic [7:0]      req_mask = 8'hFF;
   logic            busy, stall, done;
   logic [255:0]    rdata_v;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [3:0]      mem_be;
   logic [31:0]     mem_wdata;
   logic [31:0]     mem_rdata = '0;
   logic            mem_ready = 1'b1;

   int   checks = 0;
   int   failures = 0;
   int   wait_cfg = 0;
   int   wait_cnt = 0;
   txn_t exp_q[$];
   txn_t log_q[$];
   logic [255:0] exp_rdata = '0;
   logic prev_wait = 1'b0;
   txn_t prev_t;

   always #5 clk = ~clk;

   vec_mem_access #(.VL(VL), .SEW(SEW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_store (req_store),
      .req_addr  (req_addr),
      .req_be    (req_be),
      .req_wdata (req_wdata),
`ifdef VMEM_MASK_EN
      .req_mask  (req_mask),
`endif
      .busy      (busy),
      .stall     (stall),
      .done      (done),
      .rdata_v   (rdata_v),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Expected behaviour of one request: every enabled element i is one access
   // at base+4i; loads return the address as data, masked/store lanes are 0.
   task automatic model_push(input logic st, input logic [31:0] a, input logic [3:0] be,
                             input logic [255:0] wd, input logic [7:0] mk);
      txn_t t;
      exp_rdata = '0;
      for (int i = 0; i < VL; i++) begin
         if (mk[i]) begin
            t.addr  = a + 32'(i * 4);
            t.we    = st;
            t.be    = st ? be : 4'hF;
            t.wdata = st ? wd[i*32 +: 32] : 32'h0;
            exp_q.push_back(t);
            if (!st) exp_rdata[i*32 +: 32] = t.addr;
         end
      end
   endtask

   // Responder + compare process: decides mem_ready for the coming edge and
   // checks the access that edge will complete.
   initial begin
      txn_t cur;
      forever begin
         @(negedge clk);
         cur = {mem_addr, mem_we, mem_be, mem_wdata};
         if (prev_wait)
            check("hold_stable", {mem_en, cur}, {1'b1, prev_t});
         if (mem_en) begin
            if (wait_cnt == wait_cfg) begin
               mem_ready = 1'b1;
               wait_cnt  = 0;
            end else begin
               mem_ready = 1'b0;
               wait_cnt++;
            end
         end else begin
            mem_ready = (wait_cfg == 0);
         end
         mem_rdata = mem_addr;
         prev_wait = mem_en && !mem_ready;
         prev_t    = cur;
         if (mem_en && mem_ready) begin
            if (exp_q.size() == 0) check("unexpected_access", {1'b0, cur}, '0);
            else check("access", cur, exp_q.pop_front());
            log_q.push_back(cur);
         end
         if (done) check("rdata_v", rdata_v, exp_rdata);
      end
   end

   // Called just after a rising edge; that cycle is cycle 0.
   task automatic run_req(input string nm, input logic st, input logic [31:0] a,
                          input logic [3:0] be, input logic [255:0] wd, input logic [7:0] mk,
                          input int exp_done, input int exp_stall);
      int n, stall_cnt, got_done;
      logic [7:0] emk;
`ifdef VMEM_MASK_EN
      emk = mk;
`else
      emk = 8'hFF;
`endif
      log_q.delete();
      model_push(st, a, be, wd, emk);
      req_store = st; req_addr = a; req_be = be; req_wdata = wd; req_mask = mk;
      req_valid = 1'b1;
      n = 0; stall_cnt = 0; got_done = -1;
      while (n < 200 && got_done < 0) begin
         @(negedge clk);
         if (stall) stall_cnt++;
         if (done) got_done = n;
         @(posedge clk); #1;
         if (n == 0) req_valid = 1'b0;
         n++;
      end
      check({nm, "_done_cycle"}, 256'(got_done), 256'(exp_done));
      check({nm, "_stall_cycles"}, 256'(stall_cnt), 256'(exp_stall));
      check({nm, "_queue_empty"}, 256'(exp_q.size()), 256'd0);
      $display("%s: store=%0b base=%h done_cycle=%0d stall_cycles=%0d accesses=%0d",
               nm, st, a, got_done, stall_cnt, log_q.size());
   endtask

   task automatic check_reset_outputs(input string nm);
      check(nm, {busy, stall, done, mem_en, mem_we, mem_addr, mem_be, mem_wdata, rdata_v}, '0);
   endtask

   initial begin
      logic [255:0] wd;
      int n, d1, d2;
      logic st9, st10;
      for (int i = 0; i < VL; i++) wd[i*32 +: 32] = 32'hA0 + 32'(i);

      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_state");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // 1: plain load
      run_req("t1_load", 1'b0, 32'h100, 4'h0, '0, 8'hFF, 9, 9);
      check("t1_lane0", 256'(rdata_v[31:0]), 256'h100);
      check("t1_lane7", 256'(rdata_v[255:224]), 256'h11C);

      // 2: store with partial byte enables
      run_req("t2_store", 1'b1, 32'h300, 4'b0011, wd, 8'hFF, 9, 9);
      check("t2_nwrites", 256'(log_q.size()), 256'd8);
      check("t2_first", 256'(log_q[0]), 256'({32'h300, 1'b1, 4'b0011, 32'hA0}));
      check("t2_last", 256'(log_q[7].wdata), 256'hA7);

      // 3: three wait cycles per element
      wait_cfg = 3; wait_cnt = 0;
      run_req("t3_wait", 1'b0, 32'h100, 4'h0, '0, 8'hFF, 33, 33);
      wait_cfg = 0; wait_cnt = 0;

      // 4: address wrap
      run_req("t4_wrap", 1'b0, 32'hFFFF_FFF8, 4'h0, '0, 8'hFF, 9, 9);
      check("t4_addr1", 256'(log_q[1].addr), 256'hFFFF_FFFC);
      check("t4_addr2", 256'(log_q[2].addr), 256'h0);
      check("t4_addr7", 256'(log_q[7].addr), 256'h14);

      // reset in IDLE clears the held load vector
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("idle_reset");
      @(posedge clk); #1;

      // 5: reset while element 3 of a store is on the bus
      log_q.delete();
      model_push(1'b1, 32'h400, 4'hF, wd, 8'hFF);
      req_store = 1'b1; req_addr = 32'h400; req_be = 4'hF; req_wdata = wd; req_mask = 8'hFF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("t5_elem3_addr", 256'(mem_addr), 256'h40C);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("t5_after_reset");
      check("t5_writes_before_reset", 256'(log_q.size()), 256'd4);
      exp_q.delete();
      @(posedge clk); #1;
      run_req("t5_fresh", 1'b1, 32'h500, 4'b1100, wd, 8'hFF, 9, 9);
      check("t5_fresh_first", 256'(log_q[0].addr), 256'h500);

`ifdef VMEM_MASK_EN
      // 6: masked load
      run_req("t6_mask", 1'b0, 32'h100, 4'h0, '0, 8'b1010_0101, 9, 9);
      check("t6_naccess", 256'(log_q.size()), 256'd4);
      check("t6_addr2", 256'(log_q[2].addr), 256'h114);
      check("t6_lane1", 256'(rdata_v[63:32]), 256'h0);
      check("t6_lane7", 256'(rdata_v[255:224]), 256'h11C);
`endif

      // back-to-back: req_valid held through DONE, re-accepted the cycle after
      model_push(1'b0, 32'h200, 4'h0, '0, 8'hFF);
      model_push(1'b0, 32'h200, 4'h0, '0, 8'hFF);
      req_store = 1'b0; req_addr = 32'h200; req_mask = 8'hFF;
      req_valid = 1'b1;
      n = 0; d1 = -1; d2 = -1; st9 = 1'b1; st10 = 1'b0;
      while (n < 100 && d2 < 0) begin
         @(negedge clk);
         if (n == 9) st9 = stall;
         if (n == 10) st10 = stall;
         if (done) begin
            if (d1 < 0) d1 = n;
            else d2 = n;
         end
         @(posedge clk); #1;
         n++;
         if (n == 11) req_valid = 1'b0;
      end
      check("b2b_done1", 256'(d1), 256'd9);
      check("b2b_done2", 256'(d2), 256'd19);
      check("b2b_stall_done", 256'(st9), 256'd0);
      check("b2b_stall_reaccept", 256'(st10), 256'd1);
      check("b2b_queue_empty", 256'(exp_q.size()), 256'd0);
      $display("b2b: done_cycles=%0d,%0d", d1, d2);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
